// File: rtl/gfp8_group_packer.sv
// Serial GFP8 group encoder: collects GROUP_SIZE wide (mantissa, exponent) results,
// picks one shared biased exponent for the group, then requantises each element to 8 bits.
module gfp8_group_packer #(
  parameter int GROUP_SIZE = 32,
  parameter int GFP_BIAS   = 15
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [31:0]               i_mantissa,
  input  logic [7:0]                i_exponent,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [4:0]                o_exp,
  output logic [GROUP_SIZE*8-1:0]   o_man,
  output logic                      o_overflow,
  output logic                      o_underflow
);

  localparam int IDXW = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;
  localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(GROUP_SIZE - 1);
  localparam logic signed [9:0] BIAS     = 10'(GFP_BIAS);
  localparam logic signed [9:0] EG_MAX   = 10'sd31 - BIAS;
  localparam logic signed [9:0] EG_MIN   = 10'sd1 - BIAS;

  typedef enum logic [1:0] {
    COLLECT,
    EXP,
    CONVERT,
    OUTPUT
  } state_e;

  state_e                    state_q, state_d;
  logic [IDXW-1:0]           idx_q, idx_d;
  logic                      ready_q, ready_d;
  logic                      valid_q, valid_d;
  logic [4:0]                exp_q, exp_d;
  logic signed [9:0]         eg_q, eg_d;
  logic signed [9:0]         tmax_q, tmax_d;
  logic                      nonzero_q, nonzero_d;
  logic                      ovf_q, ovf_d;
  logic                      udf_q, udf_d;
  logic [GROUP_SIZE*8-1:0]   man_q, man_d;

  logic                      sign_mem [GROUP_SIZE];
  logic [31:0]               mag_mem  [GROUP_SIZE];
  logic [7:0]                exp_mem  [GROUP_SIZE];

  logic                      accept;
  logic [31:0]               in_mag;
  logic [5:0]                in_len;
  logic signed [9:0]         in_top;

  logic [31:0]               cur_mag;
  logic [7:0]                cur_exp;
  logic                      cur_sign;
  logic signed [10:0]        shift;
  logic [10:0]               neg_shift;
  logic [63:0]               shifted;
  logic                      sat;
  logic [7:0]                mag7;
  logic [7:0]                conv_val;

  logic signed [9:0]         top;
  logic signed [9:0]         biased;

  assign accept = i_valid && ready_q && (state_q == COLLECT);

  // Magnitude is kept unsigned 32-bit so that -2^31 maps to 2^31 without overflow.
  always_comb begin
    in_mag = i_mantissa[31] ? (~i_mantissa + 32'd1) : i_mantissa;
    in_len = 6'd0;
    for (int b = 0; b < 32; b++) begin
      if (in_mag[b]) in_len = 6'(b + 1);
    end
    in_top = $signed({{2{i_exponent[7]}}, i_exponent}) + $signed({4'b0000, in_len});
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      sign_mem[idx_q] <= i_mantissa[31];
      mag_mem[idx_q]  <= in_mag;
      exp_mem[idx_q]  <= i_exponent;
    end
  end

  // Requantise the element at idx_q to the shared exponent; saturation only matters
  // when the group exponent was clamped high.
  always_comb begin
    cur_mag   = mag_mem[idx_q];
    cur_exp   = exp_mem[idx_q];
    cur_sign  = sign_mem[idx_q];
    shift     = $signed({{3{cur_exp[7]}}, cur_exp}) - $signed({eg_q[9], eg_q});
    neg_shift = 11'(-shift);
    shifted   = 64'd0;
    sat       = 1'b0;
    if (!shift[10]) begin
      if (shift > 11'sd31) begin
        sat = (cur_mag != 32'd0);
      end else begin
        shifted = {32'd0, cur_mag} << shift[4:0];
        sat     = (shifted > 64'd127);
      end
    end else begin
      if (neg_shift > 11'd31) begin
        shifted = 64'd0;
      end else begin
        shifted = {32'd0, cur_mag >> neg_shift[4:0]};
      end
      sat = (shifted > 64'd127);
    end
    mag7     = sat ? 8'd127 : shifted[7:0];
    conv_val = cur_sign ? (~mag7 + 8'd1) : mag7;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ready_d   = ready_q;
    valid_d   = valid_q;
    exp_d     = exp_q;
    eg_d      = eg_q;
    tmax_d    = tmax_q;
    nonzero_d = nonzero_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    man_d     = man_q;
    top       = tmax_q - 10'sd7;
    biased    = top + BIAS;

    case (state_q)
      COLLECT: begin
        ready_d = 1'b1;
        if (accept) begin
          idx_d = idx_q + 1'b1;
          if (in_mag != 32'd0 && (!nonzero_q || in_top > tmax_q)) begin
            tmax_d    = in_top;
            nonzero_d = 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            ready_d = 1'b0;
            state_d = EXP;
          end
        end
      end

      EXP: begin
        ovf_d = 1'b0;
        udf_d = 1'b0;
        if (!nonzero_q) begin
          exp_d = 5'd0;
          eg_d  = 10'sd0;
        end else if (biased > 10'sd31) begin
          exp_d = 5'd31;
          eg_d  = EG_MAX;
          ovf_d = 1'b1;
        end else if (biased < 10'sd1) begin
          exp_d = 5'd1;
          eg_d  = EG_MIN;
          udf_d = 1'b1;
        end else begin
          exp_d = biased[4:0];
          eg_d  = top;
        end
        idx_d   = '0;
        state_d = CONVERT;
      end

      CONVERT: begin
        man_d[idx_q*8 +: 8] = conv_val;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          valid_d = 1'b1;
          state_d = OUTPUT;
        end
      end

      OUTPUT: begin
        if (i_ready) begin
          valid_d   = 1'b0;
          ovf_d     = 1'b0;
          udf_d     = 1'b0;
          idx_d     = '0;
          tmax_d    = 10'sd0;
          nonzero_d = 1'b0;
          ready_d   = 1'b1;
          state_d   = COLLECT;
        end
      end

      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= COLLECT;
      idx_q     <= '0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      exp_q     <= 5'd0;
      eg_q      <= 10'sd0;
      tmax_q    <= 10'sd0;
      nonzero_q <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      man_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      exp_q     <= exp_d;
      eg_q      <= eg_d;
      tmax_q    <= tmax_d;
      nonzero_q <= nonzero_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      man_q     <= man_d;
    end
  end

  assign o_ready     = ready_q;
  assign o_valid     = valid_q;
  assign o_exp       = exp_q;
  assign o_man       = man_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = udf_q;

endmodule
